// File: rtl/imem_responder_pkg.sv
// Shared definitions for the instruction-memory responder: default depth and
// the loader state encodings.
package imem_responder_pkg;

    localparam int IMEM_DEPTH_LOG2 = 10;

    typedef enum logic [1:0] {
        IMEM_ST_IDLE = 2'd0,
        IMEM_ST_LOAD = 2'd1,
        IMEM_ST_DONE = 2'd2
    } imem_state_e;

endpackage : imem_responder_pkg

// File: rtl/imem_ram.sv
// Single-clock word RAM: one write port and one registered read-first read port.
// The array carries no reset so it maps onto block RAM.
module imem_ram #(
    parameter int DEPTH_LOG2 = 10,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem_q [0:(1<<DEPTH_LOG2)-1];
    logic [DATA_W-1:0] rdata_q;

    // Both assignments are non-blocking, so a same-address read returns the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule : imem_ram

// File: rtl/imem_responder.sv
// Instruction-memory responder: registered fetch port plus a streaming loader
// that fills the RAM from a valid/ready word stream while holding the CPU off.
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DEPTH_LOG2 = IMEM_DEPTH_LOG2,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_oor,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic [ADDR_W-1:0] ld_len,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              ld_done,
    output logic              ld_err,
    output logic [DATA_W-1:0] ld_sum,
    output logic              cpu_hold
);

    imem_state_e       state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] remaining_q, remaining_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              err_q, err_d;
    logic              rd_oor_q, rd_oor_d;
    logic              rd_valid_q, rd_valid_d;

    logic              xfer;
    logic              ptr_in_range;
    logic              rd_in_range;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;

    assign ptr_in_range = ((ptr_q >> DEPTH_LOG2) == '0);
    assign rd_in_range  = ((rd_addr >> DEPTH_LOG2) == '0);
    assign xfer         = (state_q == IMEM_ST_LOAD) && ld_valid;
    assign ram_we       = xfer && ptr_in_range;

    imem_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ptr_q[DEPTH_LOG2-1:0]),
        .wdata (ld_data),
        .raddr (rd_addr[DEPTH_LOG2-1:0]),
        .rdata (ram_rdata)
    );

    // State and loader registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IMEM_ST_IDLE;
            ptr_q       <= '0;
            remaining_q <= '0;
            sum_q       <= '0;
            err_q       <= 1'b0;
            rd_oor_q    <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
            sum_q       <= sum_d;
            err_q       <= err_d;
            rd_oor_q    <= rd_oor_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IMEM_ST_IDLE: begin
                if (ld_start) begin
                    state_d = (ld_len != '0) ? IMEM_ST_LOAD : IMEM_ST_DONE;
                end
            end
            IMEM_ST_LOAD: begin
                if (xfer && (remaining_q == ADDR_W'(1))) begin
                    state_d = IMEM_ST_DONE;
                end
            end
            IMEM_ST_DONE: state_d = IMEM_ST_IDLE;
            default:      state_d = IMEM_ST_IDLE;
        endcase
    end

    // Loader datapath: pointer, countdown, checksum and sticky range error
    always_comb begin
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        sum_d       = sum_q;
        err_d       = err_q;
        if ((state_q == IMEM_ST_IDLE) && ld_start) begin
            ptr_d       = ld_base;
            remaining_d = ld_len;
            sum_d       = '0;
            err_d       = 1'b0;
        end else if (xfer) begin
            ptr_d       = ptr_q + ADDR_W'(1);
            remaining_d = remaining_q - ADDR_W'(1);
            sum_d       = sum_q + ld_data;
            if (!ptr_in_range) begin
                err_d = 1'b1;
            end
        end
    end

    // The RAM read register has no reset; rd_valid_q masks it to zero until
    // the first clock after reset, and rd_oor_q zeroes out-of-range words.
    always_comb begin
        rd_oor_d   = !rd_in_range;
        rd_valid_d = 1'b1;
    end

    // Output decode
    always_comb begin
        ld_ready = 1'b0;
        ld_done  = 1'b0;
        cpu_hold = 1'b0;
        unique case (state_q)
            IMEM_ST_LOAD: begin
                ld_ready = 1'b1;
                cpu_hold = 1'b1;
            end
            IMEM_ST_DONE: begin
                ld_done  = 1'b1;
                cpu_hold = 1'b1;
            end
            default: ;
        endcase
    end

    assign rd_data = (rd_valid_q && !rd_oor_q) ? ram_rdata : '0;
    assign rd_oor  = rd_oor_q;
    assign ld_err  = err_q;
    assign ld_sum  = sum_q;

endmodule : imem_responder

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: scenario tasks with a read scoreboard
// queue and a bench-side memory model.
module tb_imem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] rd_addr;
    logic [31:0] rd_data;
    logic        rd_oor;
    logic        ld_start;
    logic [15:0] ld_base;
    logic [15:0] ld_len;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        ld_done;
    logic        ld_err;
    logic [31:0] ld_sum;
    logic        cpu_hold;

    always #5 clk = ~clk;

    imem_responder dut (
        .clk      (clk),
        .reset    (reset),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_oor   (rd_oor),
        .ld_start (ld_start),
        .ld_base  (ld_base),
        .ld_len   (ld_len),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_ready (ld_ready),
        .ld_done  (ld_done),
        .ld_err   (ld_err),
        .ld_sum   (ld_sum),
        .cpu_hold (cpu_hold)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_mem [0:1023];
    logic [31:0] stim_words [0:7];
    logic [32:0] rd_exp_q [$];
    logic [31:0] exp_sum;

    int done_cnt, xfer_cnt, ready_cycles, hold_bad;

    // Drives one load; the valid pattern is either always-high or 1,0,0,1 repeating.
    task automatic drive_load(input logic [15:0] base, input logic [15:0] len, input bit toggle);
        int       widx;
        int       pi;
        bit       seen_done;
        bit       v;
        logic [3:0]  pat;
        logic [15:0] ptr;
        widx = 0; pi = 0; seen_done = 0; pat = 4'b1001; ptr = base;
        done_cnt = 0; xfer_cnt = 0; ready_cycles = 0; hold_bad = 0;
        exp_sum = '0;
        @(negedge clk);
        ld_start = 1'b1; ld_base = base; ld_len = len; ld_valid = 1'b0;
        @(posedge clk);
        for (int cyc = 0; cyc < 64; cyc++) begin
            @(negedge clk);
            ld_start = 1'b0;
            if (ld_done) begin
                done_cnt++;
                seen_done = 1;
                if (!cpu_hold) hold_bad++;
            end else if (seen_done) begin
                break;
            end
            if (ld_ready) begin
                ready_cycles++;
                if (!cpu_hold) hold_bad++;
                v = toggle ? pat[pi % 4] : 1'b1;
                pi++;
                ld_valid = v;
                ld_data  = stim_words[widx % 8];
                if (v) begin
                    if (ptr < 16'd1024) model_mem[ptr[9:0]] = ld_data;
                    exp_sum = exp_sum + ld_data;
                    ptr = ptr + 16'd1;
                    widx++;
                    xfer_cnt++;
                end
            end else begin
                ld_valid = 1'b0;
            end
            @(posedge clk);
        end
        ld_valid = 1'b0;
        $display("load base=%h len=%0d: transfers=%0d ready_cycles=%0d done_pulses=%0d sum=%h err=%b",
                 base, len, xfer_cnt, ready_cycles, done_cnt, ld_sum, ld_err);
    endtask

    // Back-to-back reads: expected word pushed when the address is driven,
    // popped and compared at the negedge after the capturing posedge.
    task automatic test_reads(input logic [15:0] addr0, input int n);
        logic [15:0] a;
        logic [32:0] exp;
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            if (i > 0) begin
                n_checks++;
                if (rd_exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL read_queue: scoreboard empty");
                end else begin
                    exp = rd_exp_q.pop_front();
                    if (rd_data !== exp[31:0] || rd_oor !== exp[32]) begin
                        n_fail++;
                        $display("FAIL read addr=%h: got data=%h oor=%b, expected data=%h oor=%b",
                                 addr0 + 16'(i - 1), rd_data, rd_oor, exp[31:0], exp[32]);
                    end else begin
                        $display("read addr=%h data=%h oor=%b", addr0 + 16'(i - 1), rd_data, rd_oor);
                    end
                end
            end
            if (i < n) begin
                a = addr0 + 16'(i);
                rd_addr = a;
                if (a < 16'd1024) rd_exp_q.push_back({1'b0, model_mem[a[9:0]]});
                else              rd_exp_q.push_back({1'b1, 32'h0});
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; rd_addr = '0; ld_start = 1'b0; ld_base = '0; ld_len = '0;
        ld_valid = 1'b0; ld_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks += 7;
        if (rd_data  !== 32'h0) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
        if (rd_oor   !== 1'b0)  begin n_fail++; $display("FAIL reset_rd_oor: got %b expected 0", rd_oor); end
        if (ld_ready !== 1'b0)  begin n_fail++; $display("FAIL reset_ld_ready: got %b expected 0", ld_ready); end
        if (ld_done  !== 1'b0)  begin n_fail++; $display("FAIL reset_ld_done: got %b expected 0", ld_done); end
        if (ld_err   !== 1'b0)  begin n_fail++; $display("FAIL reset_ld_err: got %b expected 0", ld_err); end
        if (ld_sum   !== 32'h0) begin n_fail++; $display("FAIL reset_ld_sum: got %h expected 0", ld_sum); end
        if (cpu_hold !== 1'b0)  begin n_fail++; $display("FAIL reset_cpu_hold: got %b expected 0", cpu_hold); end
        reset = 1'b0;
        $display("reset released");
    endtask

    task automatic test_basic_load();
        stim_words[0] = 32'h0100_0000; stim_words[1] = 32'h0200_0000; stim_words[2] = 32'hFFFF_FFFF;
        drive_load(16'h0000, 16'd3, 1'b0);
        n_checks += 7;
        if (done_cnt != 1)     begin n_fail++; $display("FAIL basic_done_pulses: got %0d expected 1", done_cnt); end
        if (xfer_cnt != 3)     begin n_fail++; $display("FAIL basic_transfers: got %0d expected 3", xfer_cnt); end
        if (ready_cycles != 3) begin n_fail++; $display("FAIL basic_ready_cycles: got %0d expected 3", ready_cycles); end
        if (hold_bad != 0)     begin n_fail++; $display("FAIL basic_cpu_hold: %0d cycles low, expected 0", hold_bad); end
        if (ld_sum !== 32'h02FF_FFFF) begin n_fail++; $display("FAIL basic_sum: got %h expected 02ffffff", ld_sum); end
        if (ld_err !== 1'b0)   begin n_fail++; $display("FAIL basic_err: got %b expected 0", ld_err); end
        if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL basic_hold_after: got %b expected 0", cpu_hold); end
        test_reads(16'h0000, 3);
    endtask

    task automatic test_stall();
        stim_words[0] = 32'h1111_1111; stim_words[1] = 32'h2222_2222;
        drive_load(16'h0040, 16'd2, 1'b1);
        n_checks += 4;
        if (done_cnt != 1)     begin n_fail++; $display("FAIL stall_done_pulses: got %0d expected 1", done_cnt); end
        if (xfer_cnt != 2)     begin n_fail++; $display("FAIL stall_transfers: got %0d expected 2", xfer_cnt); end
        if (ready_cycles != 4) begin n_fail++; $display("FAIL stall_ready_cycles: got %0d expected 4", ready_cycles); end
        if (ld_sum !== 32'h3333_3333) begin n_fail++; $display("FAIL stall_sum: got %h expected 33333333", ld_sum); end
        // The loader must stay idle afterwards rather than counting on past zero.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (ld_ready !== 1'b0 || cpu_hold !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_idle_after: ready=%b hold=%b expected 0/0", ld_ready, cpu_hold);
            end
        end
        test_reads(16'h0040, 2);
    endtask

    task automatic test_zero_len();
        drive_load(16'h0000, 16'd0, 1'b0);
        n_checks += 4;
        if (done_cnt != 1)     begin n_fail++; $display("FAIL zero_done_pulses: got %0d expected 1", done_cnt); end
        if (ready_cycles != 0) begin n_fail++; $display("FAIL zero_ready_cycles: got %0d expected 0", ready_cycles); end
        if (ld_sum !== 32'h0)  begin n_fail++; $display("FAIL zero_sum: got %h expected 0", ld_sum); end
        if (ld_err !== 1'b0)   begin n_fail++; $display("FAIL zero_err: got %b expected 0", ld_err); end
        test_reads(16'h0000, 1);
    endtask

    task automatic test_out_of_range();
        stim_words[0] = 32'hCAFE_F00D; stim_words[1] = 32'hDEAD_BEEF;
        drive_load(16'h03FF, 16'd2, 1'b0);
        n_checks += 3;
        if (done_cnt != 1)    begin n_fail++; $display("FAIL oor_done_pulses: got %0d expected 1", done_cnt); end
        if (ld_err !== 1'b1)  begin n_fail++; $display("FAIL oor_err: got %b expected 1", ld_err); end
        if (ld_sum !== 32'hA9AC_AEFC) begin n_fail++; $display("FAIL oor_sum: got %h expected a9acaefc", ld_sum); end
        test_reads(16'h03FF, 2);
        test_reads(16'hFFFF, 1);
        n_checks++;
        if (ld_err !== 1'b1) begin n_fail++; $display("FAIL oor_err_sticky: got %b expected 1", ld_err); end
    endtask

    task automatic test_collision();
        logic [32:0] exp;
        stim_words[0] = 32'hAAAA_0000;
        drive_load(16'h0005, 16'd1, 1'b0);
        @(negedge clk);
        ld_start = 1'b1; ld_base = 16'h0005; ld_len = 16'd1;
        @(posedge clk);
        @(negedge clk);
        ld_start = 1'b0; ld_valid = 1'b1; ld_data = 32'h5555_FFFF; rd_addr = 16'h0005;
        rd_exp_q.push_back({1'b0, model_mem[5]});
        model_mem[5] = 32'h5555_FFFF;
        @(posedge clk);
        @(negedge clk);
        ld_valid = 1'b0;
        exp = rd_exp_q.pop_front();
        n_checks += 3;
        if (rd_data !== exp[31:0]) begin n_fail++; $display("FAIL collision_read_first: got %h expected %h", rd_data, exp[31:0]); end
        if (ld_done !== 1'b1) begin n_fail++; $display("FAIL collision_done: got %b expected 1", ld_done); end
        if (ld_err !== 1'b0)  begin n_fail++; $display("FAIL collision_err_cleared: got %b expected 0", ld_err); end
        $display("collision addr=0005 read=%h", rd_data);
        rd_exp_q.push_back({1'b0, model_mem[5]});
        @(posedge clk);
        @(negedge clk);
        exp = rd_exp_q.pop_front();
        n_checks++;
        if (rd_data !== exp[31:0]) begin n_fail++; $display("FAIL collision_new_word: got %h expected %h", rd_data, exp[31:0]); end
    endtask

    task automatic test_reset_midload();
        int dones;
        dones = 0;
        @(negedge clk);
        ld_start = 1'b1; ld_base = 16'h0010; ld_len = 16'd4;
        @(posedge clk);
        @(negedge clk);
        ld_start = 1'b0; ld_valid = 1'b1; ld_data = 32'h0BAD_0001;
        model_mem[16] = 32'h0BAD_0001;
        @(posedge clk);
        @(negedge clk);
        ld_data = 32'h0BAD_0002;
        #2 reset = 1'b1;
        #1;
        n_checks += 3;
        if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL midreset_cpu_hold: got %b expected 0", cpu_hold); end
        if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL midreset_ld_ready: got %b expected 0", ld_ready); end
        if (ld_sum !== 32'h0)  begin n_fail++; $display("FAIL midreset_ld_sum: got %h expected 0", ld_sum); end
        @(negedge clk);
        reset = 1'b0; ld_valid = 1'b0;
        $display("reset asserted mid-load");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ld_done) dones++;
        end
        n_checks++;
        if (dones != 0) begin n_fail++; $display("FAIL midreset_no_done: got %0d pulses expected 0", dones); end
        test_reads(16'h0010, 1);
        stim_words[0] = 32'h1234_5678; stim_words[1] = 32'h0000_0008;
        drive_load(16'h0020, 16'd2, 1'b0);
        n_checks += 2;
        if (done_cnt != 1) begin n_fail++; $display("FAIL fresh_done_pulses: got %0d expected 1", done_cnt); end
        if (ld_sum !== 32'h1234_5680) begin n_fail++; $display("FAIL fresh_sum: got %h expected 12345680", ld_sum); end
        test_reads(16'h0020, 2);
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_stall();
        test_zero_len();
        test_out_of_range();
        test_collision();
        test_reset_midload();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_imem_responder

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder serving the controller's fetch port.
- The controller drives a 16-bit word address and samples 32-bit words from this block.
- It also contains a streaming loader that fills the memory from a host-side valid/ready word stream, starting at a programmed base address.
- While a load is in progress it holds the CPU off with cpu_hold; the CPU core's reset is the OR of reset and cpu_hold.

Parameters:
ADDR_W, 16, width of the fetch and loader address ports
DEPTH_LOG2, 10, log2 of the implemented depth in words (1024 words)
DATA_W, 32, word width

Ports:
clk  in  1  system clock, all state updates on posedge
reset  in  1  asynchronous, active-high; clears all state except memory contents
rd_addr  in  ADDR_W  fetch word address from the controller
rd_data  out  DATA_W  fetched word, registered
rd_oor  out  1  registered; high when the rd_data word came from an out-of-range address
ld_start  in  1  single-cycle pulse that begins a load
ld_base  in  ADDR_W  first write address, captured on ld_start
ld_len  in  ADDR_W  word count, captured on ld_start
ld_valid  in  1  host word valid
ld_data  in  DATA_W  host word
ld_ready  out  1  block accepts a word
ld_done  out  1  single-cycle pulse at end of a load
ld_err  out  1  sticky: at least one write in this load was dropped as out of range
ld_sum  out  DATA_W  running mod-2^32 sum of accepted words
cpu_hold  out  1  high while a load is in progress

Behaviour:
- Reset values: rd_data=0, rd_oor=0, ld_ready=0, ld_done=0, ld_err=0, ld_sum=0, cpu_hold=0, FSM=IDLE, ptr=0, remaining=0. Memory contents are untouched by reset.
- Read path, one-cycle latency:
  - On each posedge, rd_data <= mem[rd_addr] if rd_addr < 2^DEPTH_LOG2, else 0 with rd_oor=1.
  - Data is therefore valid from the posedge after the address is applied, in time for the controller's negedge sample in FETCH0_1 / FETCH1_1.
- Read/write collision on the same address in the same cycle: read-first, so rd_data returns the old word.
- FSM states:
  - IDLE: ld_ready=0, cpu_hold=0. On ld_start: ptr<=ld_base, remaining<=ld_len, ld_sum<=0, ld_err<=0. Go to LOAD if ld_len!=0, else DONE.
  - LOAD: ld_ready=1, cpu_hold=1.
    - Handshake: a word transfers in a cycle with ld_valid && ld_ready.
    - On a transfer: if ptr in range, mem[ptr]<=ld_data, else the write is dropped and ld_err<=1. Then ptr<=ptr+1 (wraps at 2^ADDR_W), remaining<=remaining-1, ld_sum<=ld_sum+ld_data (truncated to DATA_W).
    - A transfer with remaining==1 moves to DONE.
    - ld_valid low simply stalls; no timeout.
  - DONE: ld_ready=0, cpu_hold=1, ld_done=1 for exactly this one cycle, then IDLE.
- Consequently ld_ready drops in the cycle after the last transfer.
- ld_start is ignored in LOAD and DONE.
- ld_sum and ld_err hold their values in IDLE until the next ld_start.
- Reset asserted mid-load: FSM returns to IDLE immediately (asynchronously). Words already written remain in memory; the partial load is lost and ld_done does not pulse.
- Reads are always served, including during LOAD.

Decomposition:
- Shared def package: IMEM_DEPTH_LOG2 and the loader state encodings IMEM_ST_IDLE/LOAD/DONE (2-bit).
- One natural sub-module, imem_ram: single clock, one write port, one read-first registered read port, DEPTH_LOG2 x DATA_W, no reset on the array.
- imem_responder contains the FSM, the counters, range checks and the checksum.

Test Plan:
1. Reset then ld_start with base=0, len=3, words 0x01000000, 0x02000000, 0xFFFFFFFF, ld_valid held high -> ld_ready high for 3 cycles; ld_done pulses 1 cycle after the third transfer; ld_sum=0x02FFFFFF; cpu_hold high from the cycle after ld_start through DONE. Reading addresses 0..2 then returns each word 1 cycle after its address.
2. Load len=2 with ld_valid toggling 1,0,0,1 -> exactly 2 writes, ld_done pulses once, remaining never underflows.
3. ld_start with len=0 -> DONE next cycle, ld_done pulse, no writes, ld_sum=0.
4. Load base=0x03FF, len=2 with DEPTH_LOG2=10 -> mem[0x3FF] written, second word dropped, ld_err=1. A later read at rd_addr=0x0400 gives rd_data=0 and rd_oor=1.
5. Read and write to address 5 in the same cycle, old=0xAAAA0000, new=0x5555FFFF -> rd_data=0xAAAA0000; the next read gives 0x5555FFFF.
6. Assert reset during the 2nd word of a len=4 load -> cpu_hold=0 and ld_ready=0 immediately; word 1 stays in memory; no ld_done; ld_start after release begins a fresh load.
